core_exec_muldiv: RTL and testbench

CORE_EXEC_MULDIV -- requirements
Module: core_exec_muldiv

---
 rtl/core_exec_muldiv_if.sv | 29 ++
 rtl/core_exec_muldiv.sv | 195 +++++++++++++++++++
 tb/tb_core_exec_muldiv.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_exec_muldiv_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
interface core_exec_muldiv_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_src_a;
  logic [XLEN-1:0] req_src_b;
  logic [4:0]      req_rd;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic [4:0]      resp_rd;

  modport master (
    output req_valid, req_funct3, req_src_a,
    output req_src_b, req_rd, resp_ready,
    input  req_ready, resp_valid,
    input  resp_result, resp_rd
  );

  modport slave (
    input  req_valid, req_funct3, req_src_a,
    input  req_src_b, req_rd, resp_ready,
    output req_ready, resp_valid,
    output resp_result, resp_rd
  );
endinterface

// File: rtl/core_exec_muldiv.sv
// Iterative RV M-extension unit: shift-add multiply, restoring divide,
// UNROLL bits retired per cycle on operand magnitudes.
module core_exec_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              busy,
  core_exec_muldiv_if.slave io
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opd_q, opd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      ord_q, ord_d;

  logic            accept, is_div;
  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic            div_z, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN-1:0] quo, rem, res_sel;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]   t;

  logic [2:0]      f;
  logic [XLEN-1:0] sa, sb;

  assign f  = io.req_funct3;
  assign sa = io.req_src_a;
  assign sb = io.req_src_b;

  always_comb begin
    is_div  = f[2];
    a_sgn   = (f == 3'd1) || (f == 3'd2) ||
              (f == 3'd4) || (f == 3'd6);
    b_sgn   = (f == 3'd1) || (f == 3'd4) ||
              (f == 3'd6);
    a_neg   = a_sgn && sa[XLEN-1];
    b_neg   = b_sgn && sb[XLEN-1];
    a_mag   = a_neg ? -sa : sa;
    b_mag   = b_neg ? -sb : sb;
    div_z   = is_div && (sb == '0);
    div_ovf = is_div && !f[0] &&
              (sa == {1'b1, {(XLEN-1){1'b0}}}) &&
              (sb == '1);
  end

  // hi/lo hold {acc, multiplier} for MUL, {remainder, quotient} for DIV
  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    t    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        t    = {hi_n, lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], 1'b0};
        if (t >= {1'b0, opd_q}) begin
          t       = t - {1'b0, opd_q};
          lo_n[0] = 1'b1;
        end
        hi_n = t[XLEN-1:0];
      end else begin
        t    = {1'b0, hi_n} +
               (lo_n[0] ? {1'b0, opd_q} : '0);
        lo_n = {t[0], lo_n[XLEN-1:1]};
        hi_n = t[XLEN:1];
      end
    end
  end

  always_comb begin
    prod = {hi_n, lo_n};
    if (negq_q) prod = -prod;
    quo = negq_q ? -lo_n : lo_n;
    rem = negr_q ? -hi_n : hi_n;
    unique case (op_q)
      3'd0:             res_sel = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res_sel = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res_sel = quo;
      default:          res_sel = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    res_d   = res_q;
    rd_d    = rd_q;
    ord_d   = ord_q;
    io.req_ready = (state_q == IDLE) && !flush;
    accept  = io.req_valid && io.req_ready;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_d   = f;
            rd_d   = io.req_rd;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            hi_d   = '0;
            lo_d   = is_div ? a_mag : b_mag;
            opd_d  = is_div ? b_mag : a_mag;
            if (div_z) begin
              state_d = DONE;
              res_d   = f[1] ? sa : '1;
              ord_d   = io.req_rd;
            end else if (div_ovf) begin
              state_d = DONE;
              res_d   = f[1] ? '0 : sa;
              ord_d   = io.req_rd;
            end else begin
              state_d = BUSY;
              cnt_d   = CW'(N - 1);
            end
          end
        end
        BUSY: begin
          hi_d = hi_n;
          lo_d = lo_n;
          if (cnt_q == '0) begin
            state_d = DONE;
            res_d   = res_sel;
            ord_d   = rd_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (io.resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      ord_q   <= ord_d;
    end
  end

  assign io.resp_valid  = (state_q == DONE);
  assign io.resp_result = res_q;
  assign io.resp_rd     = ord_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_core_exec_muldiv.sv
// Bench for core_exec_muldiv: directed vectors, corner sequences and
// randomized ops against an arithmetic reference, for UNROLL 1 and 4.
module tb_core_exec_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush4 = 1'b0;
  logic busy1, busy4;
  logic v1 = 1'b0, v4 = 1'b0;
  logic rr1 = 1'b0, rr4 = 1'b0;
  logic [2:0]  f = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  rd = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_exec_muldiv_if #(.XLEN(32)) m1 ();
  core_exec_muldiv_if #(.XLEN(32)) m4 ();

  assign m1.req_valid  = v1;
  assign m1.req_funct3 = f;
  assign m1.req_src_a  = a;
  assign m1.req_src_b  = b;
  assign m1.req_rd     = rd;
  assign m1.resp_ready = rr1;
  assign m4.req_valid  = v4;
  assign m4.req_funct3 = f;
  assign m4.req_src_a  = a;
  assign m4.req_src_b  = b;
  assign m4.req_rd     = rd;
  assign m4.resp_ready = rr4;

  core_exec_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .busy(busy1), .io(m1.slave)
  );

  core_exec_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4),
    .busy(busy4), .io(m4.slave)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] fi,
                                         input logic [31:0] ai,
                                         input logic [31:0] bi);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    ua = longint'({32'b0, ai});
    ub = longint'({32'b0, bi});
    case (fi)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (bi == 0) return 32'hFFFF_FFFF;
        if (ai == 32'h8000_0000 && bi == 32'hFFFF_FFFF) return ai;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (bi == 0) return 32'hFFFF_FFFF;
        return ai / bi;
      end
      3'd6: begin
        if (bi == 0) return ai;
        if (ai == 32'h8000_0000 && bi == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (bi == 0) return ai;
        return ai % bi;
      end
    endcase
  endfunction

  function automatic bit is_exc(input logic [2:0] fi,
                                input logic [31:0] ai,
                                input logic [31:0] bi);
    if (!fi[2]) return 1'b0;
    if (bi == 0) return 1'b1;
    return !fi[0] && ai == 32'h8000_0000 && bi == 32'hFFFF_FFFF;
  endfunction

  task automatic start_op(input bit sel, input logic [2:0] fi,
                          input logic [31:0] ai, input logic [31:0] bi,
                          input logic [4:0] rdi);
    int g;
    @(negedge clk);
    f = fi; a = ai; b = bi; rd = rdi;
    if (sel) v4 = 1'b1;
    else v1 = 1'b1;
    g = 0;
    while (!(sel ? m4.req_ready : m1.req_ready) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (sel ? m4.resp_valid : m1.resp_valid) break;
    end
  endtask

  task automatic consume(input bit sel);
    @(negedge clk);
    if (sel) rr4 = 1'b1;
    else rr1 = 1'b1;
    @(posedge clk);
    #1;
    rr1 = 1'b0;
    rr4 = 1'b0;
  endtask

  task automatic run_op(input bit sel, input logic [2:0] fi,
                        input logic [31:0] ai, input logic [31:0] bi,
                        input logic [4:0] rdi, input logic [31:0] exp,
                        input int exp_lat, input string nm);
    int lat;
    start_op(sel, fi, ai, bi, rdi);
    wait_valid(sel, lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, sel ? m4.resp_result : m1.resp_result, exp);
    chk({nm, "_rd"}, sel ? m4.resp_rd : m1.resp_rd, rdi);
    consume(sel);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #9_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb, ex;
    logic [4:0]  rrd;

    vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'h8000_0000, 32'd0, 5'd7, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1};
    vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 1};
    vecs[9]  = '{3'd7, 32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678, 1};
    vecs[10] = '{3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33};
    vecs[11] = '{3'd7, 32'd100, 32'd7, 5'd31, 32'd2, 33};

    #2;
    chk("rst_valid", m1.resp_valid, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_result", m1.resp_result, 0);
    chk("rst_rd", m1.resp_rd, 0);
    chk("rst_valid4", m4.resp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", m1.req_ready, 1);
    chk("idle_result", m1.resp_result, 0);

    foreach (vecs[i])
      run_op(0, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // stalled response
    start_op(0, 3'd5, 32'd1000, 32'd10, 5'd12);
    wait_valid(0, lat);
    chk("stall_lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_res", m1.resp_result, 32'd100);
      chk("stall_ready", m1.req_ready, 0);
      chk("stall_valid", m1.resp_valid, 1);
    end
    consume(0);
    chk("hs_valid", m1.resp_valid, 0);
    chk("hs_ready", m1.req_ready, 1);
    chk("hs_busy", busy1, 0);

    // flush mid-BUSY
    start_op(0, 3'd0, 32'd3, 32'd5, 5'd13);
    repeat (5) @(negedge clk);
    chk("pre_flush_busy", busy1, 1);
    flush = 1'b1;
    #1;
    chk("flush_ready", m1.req_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", busy1, 0);
    chk("flush_valid", m1.resp_valid, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m1.resp_valid) seen = 1;
    end
    chk("flush_no_resp", seen, 0);
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd14, 32'd14, 33, "post_flush");

    // flush while DONE discards the result
    start_op(0, 3'd7, 32'd9, 32'd0, 5'd15);
    @(negedge clk);
    chk("done_valid", m1.resp_valid, 1);
    flush = 1'b1;
    rr1 = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    rr1 = 1'b0;
    chk("flush_done_valid", m1.resp_valid, 0);

    // UNROLL=4 instance
    run_op(1, 3'd5, 32'd100, 32'd7, 5'd16, 32'd14, 9, "u4_divu");

    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      rrd = 5'($urandom_range(0, 31));
      ex = ref_op(rf, ra, rb);
      run_op(0, rf, ra, rb, rrd, ex, is_exc(rf, ra, rb) ? 1 : 33,
             $sformatf("rnd%0d_f%0d", i, rf));
    end
    for (int i = 0; i < 80; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      rrd = 5'($urandom_range(0, 31));
      ex = ref_op(rf, ra, rb);
      run_op(1, rf, ra, rb, rrd, ex, is_exc(rf, ra, rb) ? 1 : 9,
             $sformatf("rnd4_%0d_f%0d", i, rf));
    end

    // async reset while DONE
    start_op(0, 3'd0, 32'd6, 32'd7, 5'd17);
    wait_valid(0, lat);
    chk("pre_rst_res", m1.resp_result, 32'd42);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_done_valid", m1.resp_valid, 0);
    chk("arst_done_res", m1.resp_result, 0);
    chk("arst_done_rd", m1.resp_rd, 0);
    @(negedge clk);
    rst = 1'b0;

    // async reset while BUSY (UNROLL=4)
    start_op(1, 3'd5, 32'd100, 32'd7, 5'd18);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy4", busy4, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy4", busy4, 0);
    chk("arst_valid4", m4.resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (m4.resp_valid) seen = 1;
    end
    chk("arst_no_resp4", seen, 0);
    run_op(1, 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd19, 32'd1, 9, "post_rst4");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
